// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared defaults and queue entry type for the write-back arbiter
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_W  = 5;
  localparam int WB_DEPTH  = 4;

  // One pending register write; valid drops when a newer A write kills it
  typedef struct packed {
    logic                 valid;
    logic [WB_REG_W-1:0]  dst;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// rtl/wb_match.sv - newest-first lookup of one register address among pending writes
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_W  = WB_REG_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [REG_W-1:0]              n,
  input  logic                          a_sel,
  input  logic [REG_W-1:0]              a_reg,
  input  logic [DATA_W-1:0]             a_data,
  input  logic [DEPTH-1:0]              q_valid,
  input  logic [DEPTH-1:0][REG_W-1:0]   q_reg,
  input  logic [DEPTH-1:0][DATA_W-1:0]  q_data,
  input  logic [PTR_W-1:0]              head,
  input  logic                          out_we,
  input  logic [REG_W-1:0]              out_reg,
  input  logic [DATA_W-1:0]             out_data,
  output logic                          hit,
  output logic [DATA_W-1:0]             fwd
);

  logic [PTR_W-1:0] idx;

  // Scan oldest to newest so the last match (newest value) wins; reg 0 never hits
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = head;
    if (n != '0) begin
      if (out_we && (out_reg == n)) begin
        hit = 1'b1;
        fwd = out_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PTR_W'(k);
        if (q_valid[idx] && (q_reg[idx] == n)) begin
          hit = 1'b1;
          fwd = q_data[idx];
        end
      end
      if (a_sel && (a_reg == n)) begin
        hit = 1'b1;
        fwd = a_data;
      end
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and long-latency results onto one register write port
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_W  = WB_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              wreg,
  output logic [REG_W-1:0]  writeReg,
  output logic [DATA_W-1:0] regData,
  input  logic [REG_W-1:0]  n1,
  input  logic [REG_W-1:0]  n2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] fwd1,
  output logic [DATA_W-1:0] fwd2,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0]             q_valid;
  logic [DEPTH-1:0][REG_W-1:0]  q_reg;
  logic [DEPTH-1:0][DATA_W-1:0] q_data;
  logic [PTR_W-1:0]             head, tail, pop_idx, idx;
  logic [CNT_W-1:0]             count, lead, removed;
  logic                         a_sel, b_hs, b_live, any_valid, found;
  logic                         pop, bypass, push;
  logic                         sel_we;
  logic [REG_W-1:0]             sel_reg;
  logic [DATA_W-1:0]            sel_data;

  // A pop in the same cycle does not free the slot early: ready is purely occupancy
  assign b_ready = (count != FULL);
  assign busy    = any_valid | wreg;

  // Classify sources, find the first live entry from head, and choose the output
  always_comb begin
    a_sel     = a_valid && (a_reg != '0);
    b_hs      = b_valid && b_ready;
    b_live    = b_hs && (b_reg != '0);
    any_valid = |q_valid;
    lead      = '0;
    found     = 1'b0;
    idx       = head;
    // Killed entries ahead of the first live one are dropped without a write slot
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (!found && (CNT_W'(k) < count)) begin
        if (q_valid[idx]) found = 1'b1;
        else              lead  = lead + CNT_W'(1);
      end
    end
    pop_idx  = head + lead[PTR_W-1:0];
    pop      = !a_sel && any_valid;
    bypass   = !a_sel && !any_valid && b_live;
    // B colliding with the concurrent A destination is older and therefore dead
    push     = b_live && !bypass && !(a_sel && (b_reg == a_reg));
    removed  = lead + {{PTR_W{1'b0}}, pop};
    sel_we   = 1'b0;
    sel_reg  = '0;
    sel_data = '0;
    if (a_sel) begin
      sel_we   = 1'b1;
      sel_reg  = a_reg;
      sel_data = a_data;
    end else if (pop) begin
      sel_we   = 1'b1;
      sel_reg  = q_reg[pop_idx];
      sel_data = q_data[pop_idx];
    end else if (bypass) begin
      sel_we   = 1'b1;
      sel_reg  = b_reg;
      sel_data = b_data;
    end
  end

  // Queue control, WAW kill and the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      q_valid  <= '0;
      wreg     <= 1'b0;
      writeReg <= '0;
      regData  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a_sel && q_valid[i] && (q_reg[i] == a_reg)) q_valid[i] <= 1'b0;
      end
      if (pop)  q_valid[pop_idx] <= 1'b0;
      if (push) q_valid[tail]    <= 1'b1;
      head     <= head + removed[PTR_W-1:0];
      tail     <= tail + PTR_W'(push);
      count    <= count - removed + {{PTR_W{1'b0}}, push};
      wreg     <= sel_we;
      writeReg <= sel_reg;
      regData  <= sel_data;
    end
  end

  // Payload storage needs no reset; the valid bits qualify it
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[tail]  <= b_reg;
      q_data[tail] <= b_data;
    end
  end

  wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) u_match1 (
    .n(n1), .a_sel(a_sel), .a_reg(a_reg), .a_data(a_data),
    .q_valid(q_valid), .q_reg(q_reg), .q_data(q_data), .head(head),
    .out_we(wreg), .out_reg(writeReg), .out_data(regData),
    .hit(hit1), .fwd(fwd1)
  );

  wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) u_match2 (
    .n(n2), .a_sel(a_sel), .a_reg(a_reg), .a_data(a_data),
    .q_valid(q_valid), .q_reg(q_reg), .q_data(q_data), .head(head),
    .out_we(wreg), .out_reg(writeReg), .out_data(regData),
    .hit(hit2), .fwd(fwd2)
  );

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for the write-back arbiter
module tb_wb_write_arbiter;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_reg = '0, b_reg = '0, n1 = '0, n2 = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        b_ready, wreg, hit1, hit2, busy;
  logic [4:0]  writeReg;
  logic [31:0] regData, fwd1, fwd2;

  wb_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .wreg(wreg), .writeReg(writeReg), .regData(regData),
    .n1(n1), .n2(n2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  wb_entry_t   sb[$];
  wb_entry_t   obs[$];
  wb_entry_t   e, o;
  logic [31:0] rf [32];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic wb_entry_t mk(input logic [4:0] r, input logic [31:0] d);
    wb_entry_t t;
    t.valid = 1'b1;
    t.dst   = r;
    t.data  = d;
    return t;
  endfunction

  // Register file commits on the falling edge; capture every write there
  task automatic cyc();
    @(negedge clk);
    if (rst && wreg) begin
      obs.push_back(mk(writeReg, regData));
      rf[writeReg] = regData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (wreg !== 1'b0) begin n_err++; $display("FAIL reset_wreg: got %b want 0", wreg); end
    n_vec++; if (writeReg !== 5'd0 || regData !== 32'd0) begin n_err++; $display("FAIL reset_out: got %0d/%h want 0/0", writeReg, regData); end
    n_vec++; if (b_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_flags: b_ready %b busy %b want 1 0", b_ready, busy); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_a_only();
    drive(1, 5'd3, 32'h11, 0, 0, 0);
    sb.push_back(mk(5'd3, 32'h11));
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (wreg !== 1'b1 || writeReg !== 5'd3 || regData !== 32'h11) begin n_err++; $display("FAIL a_latency: got %b %0d %h want 1 3 11", wreg, writeReg, regData); end
    repeat (2) cyc();
    n_vec++; if (rf[3] !== 32'h11) begin n_err++; $display("FAIL a_readback: got %h want 11", rf[3]); end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL a_write: got %0d/%h want %0d/%h", o.dst, o.data, e.dst, e.data); end
    end
    n_vec++; if (sb.size() != 0 || obs.size() != 0) begin n_err++; $display("FAIL a_leftover: got %0d missing %0d extra want 0 0", sb.size(), obs.size()); sb.delete(); obs.delete(); end
  endtask

  task automatic test_b_bypass();
    drive(0, 0, 0, 1, 5'd7, 32'hAB);
    n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready: got %b want 1", b_ready); end
    sb.push_back(mk(5'd7, 32'hAB));
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (wreg !== 1'b1 || writeReg !== 5'd7 || regData !== 32'hAB || busy !== 1'b1) begin n_err++; $display("FAIL bypass_latency: got %b %0d %h busy %b want 1 7 ab 1", wreg, writeReg, regData, busy); end
    cyc();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bypass_busy: got %b want 0", busy); end
    cyc();
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL bypass_write: got %0d/%h want %0d/%h", o.dst, o.data, e.dst, e.data); end
    end
    n_vec++; if (sb.size() != 0 || obs.size() != 0) begin n_err++; $display("FAIL bypass_leftover: got %0d missing %0d extra want 0 0", sb.size(), obs.size()); sb.delete(); obs.delete(); end
  endtask

  task automatic test_contention();
    wb_entry_t bq[$];
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL cont_ready_%0d: got %b want 1", i, b_ready); end
      drive(1, 5'd4, 32'h40 + i, 1, 5'd5, 32'h50 + i);
      sb.push_back(mk(5'd4, 32'h40 + i));
      bq.push_back(mk(5'd5, 32'h50 + i));
      cyc();
    end
    n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL cont_full: got b_ready %b want 0", b_ready); end
    drive(1, 5'd4, 32'h44, 1, 5'd5, 32'h54);
    sb.push_back(mk(5'd4, 32'h44));
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    while (bq.size() != 0) sb.push_back(bq.pop_front());
    repeat (8) cyc();
    n_vec++; if (b_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL cont_drained: b_ready %b busy %b want 1 0", b_ready, busy); end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL cont_write: got %0d/%h want %0d/%h", o.dst, o.data, e.dst, e.data); end
    end
    n_vec++; if (sb.size() != 0 || obs.size() != 0) begin n_err++; $display("FAIL cont_leftover: got %0d missing %0d extra want 0 0", sb.size(), obs.size()); sb.delete(); obs.delete(); end
  endtask

  task automatic test_waw_kill();
    drive(1, 5'd8, 32'h80, 1, 5'd9, 32'h1);
    sb.push_back(mk(5'd8, 32'h80));
    cyc();
    drive(1, 5'd9, 32'h2, 0, 0, 0);
    sb.push_back(mk(5'd9, 32'h2));
    cyc();
    drive(0, 0, 0, 1, 5'd10, 32'h3);
    sb.push_back(mk(5'd10, 32'h3));
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (wreg !== 1'b1 || writeReg !== 5'd10 || regData !== 32'h3) begin n_err++; $display("FAIL waw_noslot: got %b %0d %h want 1 10 3", wreg, writeReg, regData); end
    repeat (2) cyc();
    n_vec++; if (rf[9] !== 32'h2 || busy !== 1'b0) begin n_err++; $display("FAIL waw_final: got reg9 %h busy %b want 2 0", rf[9], busy); end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL waw_write: got %0d/%h want %0d/%h", o.dst, o.data, e.dst, e.data); end
    end
    n_vec++; if (sb.size() != 0 || obs.size() != 0) begin n_err++; $display("FAIL waw_leftover: got %0d missing %0d extra want 0 0", sb.size(), obs.size()); sb.delete(); obs.delete(); end
  endtask

  task automatic test_lookup();
    drive(1, 5'd1, 32'h100, 1, 5'd6, 32'hA);
    sb.push_back(mk(5'd1, 32'h100));
    cyc();
    drive(1, 5'd2, 32'h200, 1, 5'd6, 32'hB);
    sb.push_back(mk(5'd2, 32'h200));
    cyc();
    drive(1, 5'd3, 32'h300, 0, 0, 0);
    sb.push_back(mk(5'd3, 32'h300));
    sb.push_back(mk(5'd6, 32'hA));
    sb.push_back(mk(5'd6, 32'hB));
    n1 = 5'd6; n2 = 5'd0;
    #1;
    n_vec++; if (hit1 !== 1'b1 || fwd1 !== 32'hB) begin n_err++; $display("FAIL look_queue: got %b %h want 1 b", hit1, fwd1); end
    n_vec++; if (hit2 !== 1'b0 || fwd2 !== 32'h0) begin n_err++; $display("FAIL look_reg0: got %b %h want 0 0", hit2, fwd2); end
    n2 = 5'd3;
    #1;
    n_vec++; if (hit2 !== 1'b1 || fwd2 !== 32'h300) begin n_err++; $display("FAIL look_a: got %b %h want 1 300", hit2, fwd2); end
    n2 = 5'd2;
    #1;
    n_vec++; if (hit2 !== 1'b1 || fwd2 !== 32'h200) begin n_err++; $display("FAIL look_out: got %b %h want 1 200", hit2, fwd2); end
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    n1 = 5'd0; n2 = 5'd0;
    repeat (6) cyc();
    n_vec++; if (rf[6] !== 32'hB) begin n_err++; $display("FAIL look_final: got %h want b", rf[6]); end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL look_write: got %0d/%h want %0d/%h", o.dst, o.data, e.dst, e.data); end
    end
    n_vec++; if (sb.size() != 0 || obs.size() != 0) begin n_err++; $display("FAIL look_leftover: got %0d missing %0d extra want 0 0", sb.size(), obs.size()); sb.delete(); obs.delete(); end
  endtask

  task automatic test_reg0();
    drive(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (wreg !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reg0_drop: got wreg %b busy %b want 0 0", wreg, busy); end
    drive(1, 5'd0, 32'h55, 1, 5'd13, 32'h77);
    sb.push_back(mk(5'd13, 32'h77));
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (wreg !== 1'b1 || writeReg !== 5'd13) begin n_err++; $display("FAIL reg0_bypass: got %b %0d want 1 13", wreg, writeReg); end
    repeat (2) cyc();
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reg0_write: got %0d/%h want %0d/%h", o.dst, o.data, e.dst, e.data); end
    end
    n_vec++; if (sb.size() != 0 || obs.size() != 0) begin n_err++; $display("FAIL reg0_leftover: got %0d missing %0d extra want 0 0", sb.size(), obs.size()); sb.delete(); obs.delete(); end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd11, 32'hB0 + i, 1, 5'd12, 32'hC0 + i);
      if (i < 2) sb.push_back(mk(5'd11, 32'hB0 + i));
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    n_vec++; if (wreg !== 1'b0 || busy !== 1'b0 || b_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid: got wreg %b busy %b b_ready %b want 0 0 1", wreg, busy, b_ready); end
    cyc();
    rst = 1'b1;
    repeat (6) cyc();
    n_vec++; if (rf[12] !== 32'h0 || rf[11] !== 32'hB1) begin n_err++; $display("FAIL rst_rf: got r12 %h r11 %h want 0 b1", rf[12], rf[11]); end
    while (sb.size() != 0 && obs.size() != 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL rst_write: got %0d/%h want %0d/%h", o.dst, o.data, e.dst, e.data); end
    end
    n_vec++; if (sb.size() != 0 || obs.size() != 0) begin n_err++; $display("FAIL rst_leftover: got %0d missing %0d extra want 0 0", sb.size(), obs.size()); sb.delete(); obs.delete(); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_a_only();
    test_b_bypass();
    test_contention();
    test_waw_kill();
    test_lookup();
    test_reg0();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
